// File: rtl/divide_iterative_pkg.sv
// Shared constants and helpers for the iterative divider.
// Holds the state encoding and the ceil-divide used at elaboration.
package divide_iterative_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/divide_step.sv
// One combinational restoring shift-subtract step.
// Shifts the next dividend bit into the partial remainder and trial-subtracts.
module divide_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    always_comb begin
        trial   = {rem_in, bit_in};
        diff    = trial - {1'b0, divisor};
        q_bit   = (trial >= {1'b0, divisor});
        rem_out = q_bit ? WIDTH'(diff) : WIDTH'(trial);
    end

endmodule

// File: rtl/divide_iterative.sv
// Unsigned iterative divider producing STEP quotient bits per busy cycle.
// Valid/ready on both sides; results are held until consumed.
module divide_iterative
    import divide_iterative_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int STEP = ceil_div(WIDTH, LATENCY);
    localparam int ITER = ceil_div(WIDTH, STEP);
    localparam int TOT  = ITER * STEP;
    localparam int CW   = $clog2(ITER + 1);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    div_state_t       state;
    div_state_t       state_nx;
    logic [CW-1:0]    cnt;
    logic [TOT-1:0]   dvd;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic             dz;
    logic [WIDTH-1:0] rem_c [STEP+1];
    logic [STEP-1:0]  qbits;
    logic             accept;

    assign accept   = (state == IDLE) && in_valid;
    assign rem_c[0] = rem;

    // Leading padding bits are zero, so they only shift zeros out of quo.
    for (genvar i = 0; i < STEP; i++) begin : g_step
        divide_step #(
            .WIDTH(WIDTH)
        ) u_step (
            .rem_in (rem_c[i]),
            .bit_in (dvd[TOT-1-i]),
            .divisor(dsr),
            .rem_out(rem_c[i+1]),
            .q_bit  (qbits[STEP-1-i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (in_valid) state_nx = BUSY;
            BUSY: if (cnt == LAST) state_nx = DONE;
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready    = (state == IDLE);
        out_valid   = 1'b0;
        quotient    = '0;
        remainder   = '0;
        div_by_zero = 1'b0;
        if (state == DONE) begin
            out_valid   = 1'b1;
            quotient    = quo;
            remainder   = rem;
            div_by_zero = dz;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            dvd <= '0;
            dsr <= '0;
            rem <= '0;
            quo <= '0;
            dz  <= 1'b0;
        end else if (accept) begin
            cnt <= '0;
            dvd <= TOT'(dividend);
            dsr <= divisor;
            rem <= '0;
            quo <= '0;
            dz  <= (divisor == '0);
        end else if (state == BUSY) begin
            cnt <= cnt + 1'b1;
            dvd <= TOT'({dvd, {STEP{1'b0}}});
            rem <= rem_c[STEP];
            quo <= WIDTH'({quo, qbits});
        end
    end

endmodule

// File: tb/tb_divide_iterative.sv
// Scoreboard bench: eight random instances (LATENCY 1..8) plus one
// directed LATENCY=4 instance for reset, stall and handshake cases.
module tb_divide_iterative;

    localparam int W     = 8;
    localparam int NRAND = 1250;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        int         acc;
    } exp_t;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    bit   rand_go = 1'b0;
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_done  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    function automatic exp_t model(input logic [7:0] x, input logic [7:0] y,
                                   input int acc);
        exp_t e;
        e.a   = x;
        e.b   = y;
        e.acc = acc;
        e.dz  = (y == 0);
        if (y == 0) begin
            e.q = 8'hFF;
            e.r = x;
        end else begin
            e.q = x / y;
            e.r = x % y;
        end
        return e;
    endfunction

    for (genvar g = 0; g < 9; g++) begin : gl
        localparam int LAT = (g == 8) ? 4 : g + 1;
        localparam int STP = (W + LAT - 1) / LAT;
        localparam int IT  = (W + STP - 1) / STP;

        logic       iv   = 1'b0;
        logic       ordy = 1'b0;
        logic [7:0] a    = '0;
        logic [7:0] b    = '0;
        logic       ir;
        logic       ov;
        logic       dz;
        logic [7:0] q;
        logic [7:0] r;
        bit         hold = 1'b0;
        bit         seen = 1'b0;
        exp_t       sb[$];

        divide_iterative #(
            .WIDTH  (W),
            .LATENCY(LAT)
        ) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_valid   (iv),
            .in_ready   (ir),
            .dividend   (a),
            .divisor    (b),
            .out_valid  (ov),
            .out_ready  (ordy),
            .quotient   (q),
            .remainder  (r),
            .div_by_zero(dz)
        );

        function automatic string tag(input string s);
            return $sformatf("g%0d_L%0d_%s", g, LAT, s);
        endfunction

        task automatic send(input logic [7:0] x, input logic [7:0] y);
            int k = 0;
            @(negedge clk);
            a  = x;
            b  = y;
            iv = 1'b1;
            while (!ir && k < 400) begin
                @(negedge clk);
                k++;
            end
            if (!ir) begin
                chk(tag("accept_timeout"), ir, 1);
                iv = 1'b0;
            end else begin
                sb.push_back(model(x, y, cyc + 1));
                @(posedge clk);
                #1;
                iv = 1'b0;
                a  = 8'($urandom);
                b  = 8'($urandom);
            end
        endtask

        task automatic drain();
            int k = 0;
            while (sb.size() != 0 && k < 400) begin
                @(negedge clk);
                k++;
            end
            chk(tag("drain_pending"), sb.size(), 0);
        endtask

        initial begin : monitor
            exp_t e;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    sb.delete();
                    seen = 1'b0;
                end
                if (ov) begin
                    if (sb.size() == 0) begin
                        chk(tag("spurious_out_valid"), ov, 0);
                    end else begin
                        e = sb[0];
                        if (!seen) begin
                            chk(tag("latency"), cyc - e.acc, IT);
                            seen = 1'b1;
                        end
                        chk(tag("quotient"), q, e.q);
                        chk(tag("remainder"), r, e.r);
                        chk(tag("div_by_zero"), dz, e.dz);
                        chk(tag("in_ready_in_done"), ir, 0);
                        if (e.b != 0) begin
                            chk(tag("q_times_d_plus_r"),
                                int'(q) * int'(e.b) + int'(r), int'(e.a));
                            chk(tag("rem_lt_divisor"), int'(r < e.b), 1);
                        end
                    end
                end else begin
                    chk(tag("outputs_zero"), int'({q, r, dz}), 0);
                end
                ordy = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
                if (ov && ordy && sb.size() != 0) begin
                    void'(sb.pop_front());
                    seen = 1'b0;
                end
            end
        end

        if (g < 8) begin : g_rnd
            initial begin
                logic [7:0] x;
                logic [7:0] y;
                wait (rand_go);
                for (int n = 0; n < NRAND; n++) begin
                    x = 8'($urandom);
                    y = 8'($urandom);
                    if (n == 0) begin
                        x = (g == 2) ? 8'd255 : 8'd200;
                        y = (g == 2) ? 8'd1 : 8'd7;
                    end else if (n == 1) begin
                        x = 8'd13;
                        y = 8'd0;
                    end else begin
                        case ($urandom_range(0, 7))
                            0: y = 8'd0;
                            1: y = 8'($urandom_range(1, 3));
                            2: x = 8'($urandom_range(0, 15));
                            3: y = 8'hFF;
                            default: ;
                        endcase
                    end
                    send(x, y);
                end
                drain();
                n_done++;
            end
        end else begin : g_dir
            initial begin
                int k;
                rst_n = 1'b0;
                repeat (3) @(negedge clk);
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                send(8'd200, 8'd7);
                drain();
                send(8'd13, 8'd0);
                drain();

                // result held while the consumer stalls with new work offered
                hold = 1'b1;
                send(8'd100, 8'd9);
                k = 0;
                while (!ov && k < 50) begin
                    @(negedge clk);
                    k++;
                end
                chk(tag("stall_reached_done"), ov, 1);
                iv = 1'b1;
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    a = 8'($urandom);
                    b = 8'($urandom);
                end
                @(posedge clk);
                #1;
                hold = 1'b0;
                a    = 8'd50;
                b    = 8'd5;
                @(negedge clk);
                @(negedge clk);
                chk(tag("idle_after_consume_ready"), ir, 1);
                chk(tag("idle_after_consume_valid"), ov, 0);
                sb.push_back(model(8'd50, 8'd5, cyc + 1));
                @(posedge clk);
                #1;
                iv = 1'b0;
                drain();

                // reset in the second busy cycle abandons the operation
                send(8'd77, 8'd5);
                @(posedge clk);
                #2;
                rst_n = 1'b0;
                @(negedge clk);
                chk(tag("reset_out_valid"), ov, 0);
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                send(8'd9, 8'd3);
                drain();

                rand_go = 1'b1;
                n_done++;
            end
        end
    end

    initial begin : main
        int k = 0;
        while (n_done < 9 && k < 90000) begin
            @(negedge clk);
            k++;
        end
        chk("all_drivers_done", n_done, 9);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
